// File: rtl/fifo_pkg.sv
// Shared definitions for the 8x12b FIFO: link-state encodings, geometry and threshold defaults.
package fifo_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int DEPTH      = 8;
    localparam int THR_W      = 3;

    localparam logic [THR_W-1:0] THR_SUP_DEFAULT = 3'd6;
    localparam logic [THR_W-1:0] THR_INF_DEFAULT = 3'd1;

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } link_state_e;

    // A threshold pair is usable only if almost-full is non-zero and sits above almost-empty.
    function automatic logic thr_valid(input logic [THR_W-1:0] sup, input logic [THR_W-1:0] inf);
        return (sup != '0) && (inf < sup);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-file storage for the FIFO: one synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 8,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; pointers and count define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_8x12b.sv
// Synchronous FIFO with link-state gating, programmable almost-full/empty thresholds and sticky error.
module fifo_8x12b
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int DEPTH      = fifo_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            state,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [THR_W-1:0]      umbral_superior,
    input  logic [THR_W-1:0]      umbral_inferior,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [THR_W-1:0]      thr_sup, thr_inf;
    logic [DATA_WIDTH-1:0] rd_data;

    logic clear, link_up, do_read, do_write, overflow, underflow, bad_thr;

    // NOTE: every combinational output gets a value on every path, so no latches are inferred.
    always_comb begin
        clear     = reset || (state == ST_RESET);
        link_up   = (state == ST_INIT) || (state == ST_IDLE) || (state == ST_ACTIVE);
        do_read   = link_up && pop && !empty;
        do_write  = link_up && push && (!full || do_read);
        overflow  = link_up && push && full && !do_read;
        underflow = link_up && pop && empty;
        bad_thr   = (state == ST_INIT) && !thr_valid(umbral_superior, umbral_inferior);
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .PTR_W     (PTR_W)
    ) u_mem (
        .clk  (clk),
        .we   (do_write && !clear),
        .waddr(wr_ptr),
        .wdata(data_in),
        .raddr(rd_ptr),
        .rdata(rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
            thr_sup   <= THR_SUP_DEFAULT;
            thr_inf   <= THR_INF_DEFAULT;
        end else begin
            valid_out <= do_read;
            if (do_read) begin
                data_out <= rd_data;
                rd_ptr   <= rd_ptr + 1'b1;
            end
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_write && !do_read) begin
                count <= count + 1'b1;
            end else if (do_read && !do_write) begin
                count <= count - 1'b1;
            end
            if ((state == ST_INIT) && !bad_thr) begin
                thr_sup <= umbral_superior;
                thr_inf <= umbral_inferior;
            end
            if (overflow || underflow || bad_thr) begin
                error <= 1'b1;
            end
        end
    end

    // Flags come straight from the registered count, so they track the post-edge occupancy.
    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_W'(thr_sup));
    assign almost_empty = (count != '0) && (count <= CNT_W'(thr_inf));

endmodule

// File: tb/tb_fifo_8x12b.sv
// Directed scoreboard bench for fifo_8x12b: reference occupancy model plus a queue of expected words.
module tb_fifo_8x12b;
    import fifo_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  state;
    logic        push, pop;
    logic [11:0] data_in;
    logic [2:0]  umbral_superior, umbral_inferior;
    logic [11:0] data_out;
    logic        valid_out, full, empty, almost_full, almost_empty, error;

    fifo_8x12b dut (
        .clk            (clk),
        .reset          (reset),
        .state          (state),
        .push           (push),
        .pop            (pop),
        .data_in        (data_in),
        .umbral_superior(umbral_superior),
        .umbral_inferior(umbral_inferior),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .full           (full),
        .empty          (empty),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
        .error          (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          m_count  = 0;
    logic        m_err    = 1'b0;
    logic [2:0]  m_thr_s  = 3'd6;
    logic [2:0]  m_thr_i  = 3'd1;
    logic [11:0] m_last   = '0;
    logic [11:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    // Drive one cycle, update the reference model, then compare all outputs 1ns after the edge.
    task automatic step(input logic p, input logic q, input logic [11:0] d);
        logic act, rd, wr;
        logic [11:0] exp_word;
        push    = p;
        pop     = q;
        data_in = d;
        rd = 1'b0;
        wr = 1'b0;
        if (reset || state == ST_RESET) begin
            m_count = 0;
            m_err   = 1'b0;
            m_thr_s = 3'd6;
            m_thr_i = 3'd1;
            m_last  = '0;
            sb.delete();
        end else begin
            act = (state == ST_INIT) || (state == ST_IDLE) || (state == ST_ACTIVE);
            rd  = act && q && (m_count != 0);
            wr  = act && p && ((m_count != 8) || rd);
            if (act && q && m_count == 0) m_err = 1'b1;
            if (act && p && m_count == 8 && !rd) m_err = 1'b1;
            if (state == ST_INIT) begin
                if (umbral_superior == 3'd0 || umbral_inferior >= umbral_superior) begin
                    m_err = 1'b1;
                end else begin
                    m_thr_s = umbral_superior;
                    m_thr_i = umbral_inferior;
                end
            end
            if (wr) sb.push_back(d);
            m_count = m_count + int'(wr) - int'(rd);
        end
        @(posedge clk);
        #1;
        cyc++;
        check("valid_out", 32'(valid_out), 32'(rd));
        if (valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_underrun", 32'(sb.size()), 32'd1);
            end else begin
                exp_word = sb.pop_front();
                m_last   = exp_word;
            end
        end
        check("data_out", 32'(data_out), 32'(m_last));
        check("full", 32'(full), 32'(m_count == 8));
        check("empty", 32'(empty), 32'(m_count == 0));
        check("almost_full", 32'(almost_full), 32'(m_count >= int'(m_thr_s)));
        check("almost_empty", 32'(almost_empty), 32'(m_count != 0 && m_count <= int'(m_thr_i)));
        check("error", 32'(error), 32'(m_err));
    endtask

    initial begin
        reset           = 1'b1;
        state           = ST_IDLE;
        push            = 1'b0;
        pop             = 1'b0;
        data_in         = '0;
        umbral_superior = 3'd6;
        umbral_inferior = 3'd1;

        // Reset for two cycles; the push in the second reset cycle must be ignored.
        step(1'b0, 1'b0, 12'h000);
        step(1'b1, 1'b0, 12'hAAA);
        reset = 1'b0;

        state = ST_INIT;
        step(1'b0, 1'b0, 12'h000);
        state = ST_ACTIVE;

        // Fill: pushes 1..9, the ninth overflows.
        for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 12'(i));
        // Drain: 11 pops, the last three underflow.
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 12'h000);

        // Simultaneous push/pop starting from empty: first cycle writes only.
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 12'h100 + 12'(i));

        // Soft reset via link state clears the sticky error and the stored word.
        state = ST_RESET;
        step(1'b1, 1'b0, 12'hBAD);
        state = ST_ACTIVE;

        // Fill to 8, then push/pop together across the pointer wrap.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 12'h200 + 12'(i));
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 12'h300 + 12'(i));

        // Pop down to 5 and load non-default thresholds 4/2.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 12'h000);
        umbral_superior = 3'd4;
        umbral_inferior = 3'd2;
        state = ST_INIT;
        step(1'b0, 1'b0, 12'h000);
        state = ST_ACTIVE;

        // Hard reset at count 5 with a push in the same cycle.
        reset = 1'b1;
        step(1'b1, 1'b0, 12'hEEE);
        reset = 1'b0;

        // Unknown link state: push/pop ignored, no error.
        state = 4'b0011;
        step(1'b1, 1'b1, 12'h777);
        state = ST_ACTIVE;

        // Refill to 6 to confirm thresholds came back as 6/1.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 12'h400 + 12'(i));

        // Invalid threshold pair 2/5 keeps 6/1 and raises error.
        umbral_superior = 3'd2;
        umbral_inferior = 3'd5;
        state = ST_INIT;
        step(1'b0, 1'b0, 12'h000);
        state = ST_ACTIVE;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 12'h000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
